// File: rtl/sd_dat_pkg.sv
// Shared types and constants for the SD DAT write path (framer + per-line CRC16).
package sd_dat_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_PREP  = 4'd1,
    ST_START = 4'd2,
    ST_DATA  = 4'd3,
    ST_CRC   = 4'd4,
    ST_END   = 4'd5,
    ST_TURN  = 4'd6,
    ST_TOKEN = 4'd7,
    ST_BUSY  = 4'd8
  } dat_state_t;

  localparam logic [15:0] CRC16_POLY    = 16'h1021;
  localparam logic [2:0]  TOKEN_OK      = 3'b010;
  localparam logic [2:0]  TOKEN_CRC_ERR = 3'b101;
  localparam int          CRC_LEN       = 16;

  // One serial CRC16-CCITT step, message bit applied MSB-first.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/sd_crc16.sv
// Serial 1-bit CRC16-CCITT accumulator for one DAT line; seed is zero.
module sd_crc16
  import sd_dat_pkg::*;
(
  input  logic        sd_clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  input  logic        din,
  output logic [15:0] crc
);

  // Clear wins over enable so a new block always starts from the zero seed.
  always_ff @(posedge sd_clock or posedge reset) begin
    if (reset) begin
      crc <= '0;
    end else if (clear) begin
      crc <= '0;
    end else if (enable) begin
      crc <= crc16_step(crc, din);
    end
  end

endmodule

// File: rtl/dat_tx_framer.sv
// Write-direction DAT framer: pulls one block of nibbles from the serializer,
// sends start bit / data / per-line CRC16 / end bit, then checks the card's
// CRC-status token on DAT0 and waits out busy.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | bus released, waiting for start
// PREP     | serializer pipeline fill (SER_LAT-1 cycles, skipped if SER_LAT=1)
// START    | drive start bit (all lines 0) for one cycle
// DATA     | drive one captured nibble per cycle, CRCs accumulate
// CRC      | drive 16 CRC bits per line, MSB first
// END      | drive end bit (all lines 1)
// TURN     | release the bus, arm the token timeout
// TOKEN    | wait for token start bit, then 3 status bits and the end bit
// BUSY     | wait for DAT0 high, then pulse done
module dat_tx_framer
  import sd_dat_pkg::*;
#(
  parameter int BLOCK_BYTES    = 512,
  parameter int DAT_W          = 4,
  parameter int SER_LAT        = 1,
  parameter int STATUS_TIMEOUT = 8
) (
  input  logic             sd_clock,
  input  logic             reset,
  input  logic             start,
  input  logic [DAT_W-1:0] ser_data,
  output logic             ser_req,
  output logic [DAT_W-1:0] dat_out,
  output logic             dat_oe,
  input  logic [DAT_W-1:0] dat_in,
  output logic             busy,
  output logic             done,
  output logic             crc_ok,
  output logic             tout
);

  localparam int NIBBLES  = 2 * BLOCK_BYTES;
  localparam int NIB_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int PREP_CYC = (SER_LAT > 1) ? SER_LAT - 1 : 1;
  localparam int PREP_W   = (PREP_CYC > 1) ? $clog2(PREP_CYC) : 1;
  localparam int TMR_W    = (STATUS_TIMEOUT > 1) ? $clog2(STATUS_TIMEOUT) : 1;

  dat_state_t        state;
  logic [NIB_W-1:0]  req_cnt;
  logic [NIB_W-1:0]  nib_cnt;
  logic [3:0]        bit_cnt;
  logic [PREP_W-1:0] prep_cnt;
  logic [TMR_W-1:0]  tmr;
  logic              tok_seen;
  logic [1:0]        tok_cnt;
  logic [2:0]        tok_sr;
  logic              tok_good;

  logic              launch;
  logic              crc_en;
  logic [15:0]       crc_q [DAT_W];
  logic [DAT_W-1:0]  crc_bit;
  logic              unused_dat_in;

  // Only DAT0 carries the token and busy; the other lines are don't-care.
  assign unused_dat_in = ^dat_in;

  // A start coinciding with the done pulse is dropped so the CCF sees a clean handshake.
  assign launch = (state == ST_IDLE) && start && !done;
  assign crc_en = (state == ST_DATA);

  for (genvar g = 0; g < DAT_W; g++) begin : g_line
    sd_crc16 u_crc (
      .sd_clock (sd_clock),
      .reset    (reset),
      .clear    (launch),
      .enable   (crc_en),
      .din      (ser_data[g]),
      .crc      (crc_q[g])
    );
    assign crc_bit[g] = crc_q[g][bit_cnt];
  end

  // ser_req window: exactly NIBBLES consecutive cycles from launch, timed independently of SER_LAT.
  always_ff @(posedge sd_clock or posedge reset) begin
    if (reset) begin
      ser_req <= 1'b0;
      req_cnt <= '0;
    end else if (launch) begin
      ser_req <= 1'b1;
      req_cnt <= NIB_W'(NIBBLES - 1);
    end else if (ser_req) begin
      if (req_cnt == '0) begin
        ser_req <= 1'b0;
      end else begin
        req_cnt <= req_cnt - NIB_W'(1);
      end
    end
  end

  // Frame sequencer; every output is registered here.
  always_ff @(posedge sd_clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      dat_out  <= '1;
      dat_oe   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      crc_ok   <= 1'b0;
      tout     <= 1'b0;
      nib_cnt  <= '0;
      bit_cnt  <= '0;
      prep_cnt <= '0;
      tmr      <= '0;
      tok_seen <= 1'b0;
      tok_cnt  <= '0;
      tok_sr   <= '0;
      tok_good <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (launch) begin
            busy     <= 1'b1;
            crc_ok   <= 1'b0;
            tout     <= 1'b0;
            tok_good <= 1'b0;
            prep_cnt <= PREP_W'(PREP_CYC - 1);
            state    <= (SER_LAT > 1) ? ST_PREP : ST_START;
          end
        end

        ST_PREP: begin
          if (prep_cnt == '0) begin
            state <= ST_START;
          end else begin
            prep_cnt <= prep_cnt - PREP_W'(1);
          end
        end

        ST_START: begin
          dat_oe  <= 1'b1;
          dat_out <= '0;
          nib_cnt <= '0;
          state   <= ST_DATA;
        end

        ST_DATA: begin
          dat_out <= ser_data;
          if (nib_cnt == NIB_W'(NIBBLES - 1)) begin
            nib_cnt <= '0;
            bit_cnt <= 4'(CRC_LEN - 1);
            state   <= ST_CRC;
          end else begin
            nib_cnt <= nib_cnt + NIB_W'(1);
          end
        end

        // bit_cnt counts down 15..0, which is also the CRC bit index sent this cycle.
        ST_CRC: begin
          dat_out <= crc_bit;
          if (bit_cnt == 4'd0) begin
            state <= ST_END;
          end else begin
            bit_cnt <= bit_cnt - 4'd1;
          end
        end

        ST_END: begin
          dat_out <= '1;
          state   <= ST_TURN;
        end

        ST_TURN: begin
          dat_oe   <= 1'b0;
          tmr      <= TMR_W'(STATUS_TIMEOUT - 1);
          tok_seen <= 1'b0;
          tok_cnt  <= '0;
          tok_sr   <= '0;
          state    <= ST_TOKEN;
        end

        // Start bit seen on the last allowed sample still counts as a token.
        ST_TOKEN: begin
          if (!tok_seen) begin
            if (!dat_in[0]) begin
              tok_seen <= 1'b1;
              tok_cnt  <= '0;
            end else if (tmr == '0) begin
              done   <= 1'b1;
              tout   <= 1'b1;
              crc_ok <= 1'b0;
              busy   <= 1'b0;
              state  <= ST_IDLE;
            end else begin
              tmr <= tmr - TMR_W'(1);
            end
          end else if (tok_cnt == 2'd3) begin
            tok_good <= (tok_sr == TOKEN_OK) && dat_in[0];
            state    <= ST_BUSY;
          end else begin
            tok_sr  <= {tok_sr[1:0], dat_in[0]};
            tok_cnt <= tok_cnt + 2'd1;
          end
        end

        ST_BUSY: begin
          if (dat_in[0]) begin
            done   <= 1'b1;
            crc_ok <= tok_good;
            tout   <= 1'b0;
            busy   <= 1'b0;
            state  <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dat_tx_framer.sv
// Bench for dat_tx_framer: two instances (SER_LAT=1 and 2, 4-byte blocks),
// expected frame timeline computed per cycle from the framing rules.
`timescale 1ns/1ps
module tb_dat_tx_framer;
  import sd_dat_pkg::*;

  localparam int NIB  = 8;
  localparam int TOUT = 8;
  localparam logic [9:0] IDLE_VEC = 10'h00F;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       start_v    [2];
  logic [3:0] ser_data_v [2];
  logic [3:0] dat_in_v   [2];
  logic       ser_req_v  [2];
  logic [3:0] dat_out_v  [2];
  logic       dat_oe_v   [2];
  logic       busy_v     [2];
  logic       done_v     [2];
  logic       crc_ok_v   [2];
  logic       tout_v     [2];

  dat_tx_framer #(.BLOCK_BYTES(4), .DAT_W(4), .SER_LAT(1), .STATUS_TIMEOUT(TOUT)) u_lat1 (
    .sd_clock(clk), .reset(reset), .start(start_v[0]), .ser_data(ser_data_v[0]),
    .ser_req(ser_req_v[0]), .dat_out(dat_out_v[0]), .dat_oe(dat_oe_v[0]), .dat_in(dat_in_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .crc_ok(crc_ok_v[0]), .tout(tout_v[0]));

  dat_tx_framer #(.BLOCK_BYTES(4), .DAT_W(4), .SER_LAT(2), .STATUS_TIMEOUT(TOUT)) u_lat2 (
    .sd_clock(clk), .reset(reset), .start(start_v[1]), .ser_data(ser_data_v[1]),
    .ser_req(ser_req_v[1]), .dat_out(dat_out_v[1]), .dat_oe(dat_oe_v[1]), .dat_in(dat_in_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .crc_ok(crc_ok_v[1]), .tout(tout_v[1]));

  int errors = 0;
  int checks = 0;
  logic [3:0]  frame_nib [NIB];
  logic [15:0] crc_exp   [4];

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // CRC as the remainder of M(x)*x^16 divided by x^16+x^12+x^5+1.
  function automatic logic [15:0] ref_crc(input int ln);
    logic [16:0] r;
    r = '0;
    for (int j = 0; j < NIB + 16; j++) begin
      r = {r[15:0], (j < NIB) ? frame_nib[j][ln] : 1'b0};
      if (r[16]) r = r ^ 17'h11021;
    end
    return r[15:0];
  endfunction

  // Pad value after edge c (edge 0 = the one that accepts start).
  function automatic logic [3:0] exp_dat_out(input int c, input int lat);
    logic [3:0] v;
    int k;
    v = 4'hF;
    if (c == lat) v = 4'h0;
    else if (c >= lat + 1 && c <= lat + NIB) v = frame_nib[c - lat - 1];
    else if (c >= lat + NIB + 1 && c <= lat + NIB + 16) begin
      k = c - lat - NIB - 1;
      for (int ln = 0; ln < 4; ln++) v[ln] = crc_exp[ln][15 - k];
    end
    return v;
  endfunction

  // What the card puts on DAT0 for edge e; r is the bus-release edge.
  function automatic logic din0(input int e, input int r, input int tok_d,
                                input logic [2:0] st, input logic endbit, input int bcyc);
    int ts;
    if (tok_d == 0) return 1'b1;
    ts = r + tok_d;
    if (e < ts) return 1'b1;
    if (e == ts) return 1'b0;
    if (e <= ts + 3) return st[2 - (e - ts - 1)];
    if (e == ts + 4) return endbit;
    if (e <= ts + 4 + bcyc) return 1'b0;
    return 1'b1;
  endfunction

  // One transaction on instance idx; tok_d=0 means the card never answers.
  task automatic run_frame(input int idx, input string name, input int tok_d,
                           input logic [2:0] status, input logic endbit, input int bcyc,
                           input int abort_at, input int restart_at, input bit start_on_done);
    int lat, rel, c_done;
    logic ok_exp, tout_exp;
    logic [9:0] obs, exp;
    lat      = idx + 1;
    rel      = lat + NIB + 18;
    c_done   = (tok_d == 0) ? rel + TOUT : rel + tok_d + 5 + bcyc;
    ok_exp   = (tok_d != 0) && (status == TOKEN_OK) && endbit;
    tout_exp = (tok_d == 0);
    for (int ln = 0; ln < 4; ln++) crc_exp[ln] = ref_crc(ln);
    start_v[idx]    = 1'b1;
    dat_in_v[idx]   = {3'($urandom), 1'b1};
    ser_data_v[idx] = 4'($urandom);
    for (int c = 0; c <= c_done + 2; c++) begin
      @(negedge clk);
      start_v[idx] = 1'b0;
      exp = {(c < NIB), (c >= lat && c < rel), (c < c_done), (c == c_done),
             (c >= c_done) && ok_exp, (c >= c_done) && tout_exp, exp_dat_out(c, lat)};
      obs = {ser_req_v[idx], dat_oe_v[idx], busy_v[idx], done_v[idx],
             crc_ok_v[idx], tout_v[idx], dat_out_v[idx]};
      chk($sformatf("%s c%0d", name, c), obs, exp);
      if (c == abort_at) begin
        reset = 1'b1;
        #1;
        obs = {ser_req_v[idx], dat_oe_v[idx], busy_v[idx], done_v[idx],
               crc_ok_v[idx], tout_v[idx], dat_out_v[idx]};
        chk($sformatf("%s abort_now", name), obs, IDLE_VEC);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          obs = {ser_req_v[idx], dat_oe_v[idx], busy_v[idx], done_v[idx],
                 crc_ok_v[idx], tout_v[idx], dat_out_v[idx]};
          chk($sformatf("%s after_abort%0d", name, k), obs, IDLE_VEC);
        end
        dat_in_v[idx] = 4'hF;
        return;
      end
      ser_data_v[idx] = (c >= lat && c < lat + NIB) ? frame_nib[c - lat] : 4'($urandom);
      dat_in_v[idx]   = {3'($urandom), din0(c + 1, rel, tok_d, status, endbit, bcyc)};
      if (c == restart_at) start_v[idx] = 1'b1;
      if (start_on_done && c == c_done) start_v[idx] = 1'b1;
    end
    start_v[idx]  = 1'b0;
    dat_in_v[idx] = 4'hF;
  endtask

  task automatic fill_random();
    for (int j = 0; j < NIB; j++) frame_nib[j] = 4'($urandom);
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start_v[i]    = 1'b0;
      ser_data_v[i] = 4'h0;
      dat_in_v[i]   = 4'hF;
    end
    repeat (2) @(negedge clk);
    chk("reset lat1", {ser_req_v[0], dat_oe_v[0], busy_v[0], done_v[0], crc_ok_v[0], tout_v[0], dat_out_v[0]}, IDLE_VEC);
    chk("reset lat2", {ser_req_v[1], dat_oe_v[1], busy_v[1], done_v[1], crc_ok_v[1], tout_v[1], dat_out_v[1]}, IDLE_VEC);
    reset = 1'b0;
    @(negedge clk);

    for (int j = 0; j < NIB; j++) frame_nib[j] = 4'h0;
    run_frame(0, "t1_zero", 2, TOKEN_OK, 1'b1, 3, -1, -1, 1'b0);

    for (int j = 0; j < NIB; j++) frame_nib[j] = 4'(j + 1);
    run_frame(0, "t2_seq", 1, TOKEN_OK, 1'b1, 0, -1, -1, 1'b1);

    fill_random();
    run_frame(0, "t3_crcerr", 3, TOKEN_CRC_ERR, 1'b1, 2, -1, -1, 1'b0);

    fill_random();
    run_frame(0, "t4_tout", 0, TOKEN_OK, 1'b1, 0, -1, -1, 1'b1);

    fill_random();
    run_frame(0, "t_noend", TOUT, TOKEN_OK, 1'b0, 1, -1, -1, 1'b0);

    fill_random();
    run_frame(0, "t5_abort", 2, TOKEN_OK, 1'b1, 1, 4, -1, 1'b0);

    fill_random();
    run_frame(0, "t5_clean", 2, TOKEN_OK, 1'b1, 1, -1, -1, 1'b0);

    fill_random();
    run_frame(1, "t6_lat2", 4, TOKEN_OK, 1'b1, 2, -1, 2 + NIB + 5, 1'b1);

    for (int n = 0; n < 8; n++) begin
      fill_random();
      run_frame(n % 2, $sformatf("rnd%0d", n), $urandom_range(0, TOUT),
                3'($urandom), ($urandom_range(0, 3) != 0), $urandom_range(0, 4),
                -1, $urandom_range(0, 27), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
